// File: rtl/point_fifo.sv
// point_fifo: circular buffer of 12-bit (x, y) points that feeds a downstream line generator
// through a strobe / hold / wait handshake. Define POINT_FIFO_BLANK_EN to carry a per-point beam-blank bit.
module point_fifo #(
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [11:0]            wr_x,
  input  logic [11:0]            wr_y,
  input  logic                   wr_en,
`ifdef POINT_FIFO_BLANK_EN
  input  logic                   wr_blank,
  output logic                   blank,
`endif
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   line_ready,
  output logic [11:0]            x,
  output logic [11:0]            y,
  output logic                   strobe
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef POINT_FIFO_BLANK_EN
  localparam int EW = 25;
`else
  localparam int EW = 24;
`endif

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    WAIT
  } state_t;

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_data;
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_next;
  logic [11:0]   x_q;
  logic [11:0]   y_q;
  logic          wr_accept;
  logic          pop;
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] hold_cnt;
  logic [CW-1:0] hold_cnt_next;

`ifdef POINT_FIFO_BLANK_EN
  logic blank_q;
  assign wr_data = {wr_blank, wr_x, wr_y};
  assign blank   = strobe ? head[24] : blank_q;
`else
  assign wr_data = {wr_x, wr_y};
`endif

  assign head      = mem[rd_ptr];
  assign wr_accept = wr_en && !full;
  assign strobe    = pop;

  // The head point is shown during the strobe cycle itself, then held in x_q/y_q until the next strobe.
  assign x = strobe ? head[23:12] : x_q;
  assign y = strobe ? head[11:0]  : y_q;

  always_comb begin
    level_next = level;
    if (wr_accept && !pop) begin
      level_next = level + 1'b1;
    end else if (!wr_accept && pop) begin
      level_next = level - 1'b1;
    end
  end

  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if ((level != '0) && line_ready) begin
          pop = 1'b1;
          if (HOLD_CYCLES == 0) begin
            state_next = WAIT;
          end else begin
            state_next    = HOLD;
            hold_cnt_next = '0;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == CW'(HOLD_CYCLES - 1)) begin
          state_next = WAIT;
        end else begin
          hold_cnt_next = hold_cnt + 1'b1;
        end
      end
      WAIT: begin
        if (line_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // Storage is not reset; a cleared level makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pop) begin
      x_q <= head[23:12];
      y_q <= head[11:0];
    end
  end

`ifdef POINT_FIFO_BLANK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      blank_q <= 1'b1;
    end else if (pop) begin
      blank_q <= head[24];
    end
  end
`endif

endmodule
